// File: rtl/bus_hold_arbiter.sv
// Round-robin HOLD/HLDA bus arbiter for 8088 secondary masters.
// Ownership is granted only while HLDA is held, with an optional per-grant tenure limit.
module bus_hold_arbiter #(
  parameter int NREQ       = 2,
  parameter int MAX_TENURE = 64
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic            HOLD,
  input  logic            HLDA,
  output logic            BUSY,
  output logic            TIMEOUT
);

  localparam int PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HREQ,
    S_GRANT,
    S_HANDOFF,
    S_RELEASE
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic            hold_q;
  logic            tmo_q;
  logic [PTR_W-1:0] ptr_q;
  logic [7:0]      cnt_q;

  logic [PTR_W-1:0] win_d;
  logic [NREQ-1:0]  win_oh_d;
  logic [7:0]       cnt_d;
  logic             expire_d;
  logic             owner_req_d;

  // First requester after the last owner, scanning upward modulo NREQ.
  always_comb begin : pick_winner
    logic             found;
    logic [PTR_W-1:0] idx;
    win_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % NREQ);
      if (!found && REQ[idx]) begin
        win_d = idx;
        found = 1'b1;
      end
    end
  end

  assign win_oh_d    = NREQ'(1) << win_d;
  assign owner_req_d = |(REQ & gnt_q);
  assign cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  // cnt_q counts completed grant cycles, so cnt_d is the length including this one.
  assign expire_d    = (MAX_TENURE != 0) && (int'(cnt_d) == MAX_TENURE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      hold_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ptr_q   <= PTR_W'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|REQ) begin
            state_q <= S_HREQ;
            hold_q  <= 1'b1;
          end
        end
        S_HREQ: begin
          if (HLDA) begin
            if (|REQ) begin
              state_q <= S_GRANT;
              gnt_q   <= win_oh_d;
              ptr_q   <= win_d;
              cnt_q   <= '0;
            end else begin
              state_q <= S_RELEASE;
              hold_q  <= 1'b0;
            end
          end
        end
        S_GRANT: begin
          // Losing HLDA outranks everything: the bus is no longer ours to hand off.
          if (!HLDA) begin
            state_q <= S_HREQ;
            gnt_q   <= '0;
          end else if (!owner_req_d) begin
            state_q <= S_HANDOFF;
            gnt_q   <= '0;
          end else if (expire_d) begin
            state_q <= S_HANDOFF;
            gnt_q   <= '0;
            tmo_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_HANDOFF: begin
          if (|REQ) begin
            if (HLDA) begin
              state_q <= S_GRANT;
              gnt_q   <= win_oh_d;
              ptr_q   <= win_d;
              cnt_q   <= '0;
            end else begin
              state_q <= S_HREQ;
            end
          end else begin
            state_q <= S_RELEASE;
            hold_q  <= 1'b0;
          end
        end
        S_RELEASE: begin
          if (!HLDA) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT     = gnt_q;
  assign HOLD    = hold_q;
  assign BUSY    = |gnt_q;
  assign TIMEOUT = tmo_q;

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Bench for bus_hold_arbiter: randomized requesters and a behavioural 8088 HOLD/HLDA
// responder, with a cycle scoreboard fed by an ownership-level reference model.
module tb_bus_hold_arbiter;

  localparam int N  = 4;
  localparam int MT = 8;

  logic         CLK   = 1'b0;
  logic         RESET = 1'b0;
  logic         HLDA  = 1'b0;
  logic [N-1:0] REQ   = '0;
  logic [N-1:0] GNT;
  logic         HOLD;
  logic         BUSY;
  logic         TIMEOUT;
  bit           drop_en = 1'b0;

  bus_hold_arbiter #(.NREQ(N), .MAX_TENURE(MT)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT), .HOLD(HOLD),
    .HLDA(HLDA), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks who owns the bus and how long, not an encoded FSM.
  typedef struct {
    int gnt;
    int hold;
    int busy;
    int tmo;
  } exp_t;
  exp_t sbq[$];

  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_OWN = 2, PH_GAP = 3, PH_REL = 4;
  int ph, owner, last, held_cycles, m_gnt, m_hold, m_tmo;

  function automatic int pick(int r, int from);
    for (int i = 1; i <= N; i++) begin
      int c = (from + i) % N;
      if (((r >> c) & 1) != 0) return c;
    end
    return from;
  endfunction

  task automatic give(int r);
    owner       = pick(r, last);
    last        = owner;
    m_gnt       = 1 << owner;
    held_cycles = 1;
    ph          = PH_OWN;
  endtask

  task automatic model_step();
    int   r;
    bit   a;
    exp_t e;
    r = int'(REQ);
    a = HLDA;
    if (!RESET) begin
      ph = PH_IDLE; last = N - 1; owner = -1; held_cycles = 0;
      m_gnt = 0; m_hold = 0; m_tmo = 0;
    end else begin
      m_tmo = 0;
      case (ph)
        PH_IDLE: if (r != 0) begin ph = PH_WAIT; m_hold = 1; end
        PH_WAIT: if (a) begin
          if (r != 0) give(r);
          else begin ph = PH_REL; m_hold = 0; end
        end
        PH_OWN: begin
          if (!a) begin m_gnt = 0; ph = PH_WAIT; end
          else if (((r >> owner) & 1) == 0) begin m_gnt = 0; ph = PH_GAP; end
          else if (held_cycles == MT) begin m_gnt = 0; m_tmo = 1; ph = PH_GAP; end
          else held_cycles++;
        end
        PH_GAP: begin
          if (r == 0) begin ph = PH_REL; m_hold = 0; end
          else if (!a) ph = PH_WAIT;
          else give(r);
        end
        default: if (!a) ph = PH_IDLE;
      endcase
    end
    e.gnt = m_gnt; e.hold = m_hold; e.busy = (m_gnt != 0) ? 1 : 0; e.tmo = m_tmo;
    sbq.push_back(e);
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(posedge CLK);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("sb_gnt", int'(GNT), e.gnt);
      check("sb_hold", int'(HOLD), e.hold);
      check("sb_busy", int'(BUSY), e.busy);
      check("sb_timeout", int'(TIMEOUT), e.tmo);
    end
  end

  // 8088 side: HLDA follows HOLD after 0..4 cycles; optionally drops HLDA spontaneously.
  initial begin
    int w = 0;
    forever begin
      @(negedge CLK);
      if (HOLD !== HLDA) begin
        if (w > 0) w--;
        else begin
          HLDA = HOLD;
          w = $urandom_range(0, 4);
        end
      end else if (drop_en && HLDA && HOLD && $urandom_range(0, 63) == 0) begin
        HLDA = 1'b0;
        w = $urandom_range(0, 4);
      end
    end
  end

  task automatic wait_gnt(string name, int budget);
    int n = 0;
    while (GNT == '0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(name, (GNT != '0) ? 1 : 0, 1);
  endtask

  initial begin
    int order[$];
    int exp_order[5] = '{2, 4, 8, 1, 2};
    int prev, tmo_cnt, hold_low, gnt_cyc, rv, g;

    repeat (3) @(negedge CLK);
    check("rst_gnt", int'(GNT), 0);
    check("rst_hold", int'(HOLD), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_timeout", int'(TIMEOUT), 0);
    RESET = 1'b1;

    // Single requester
    REQ = 4'b0001;
    wait_gnt("single_wait", 40);
    check("single_gnt", int'(GNT), 1);
    repeat (5) @(negedge CLK);
    REQ = 4'b0000;
    repeat (15) @(negedge CLK);

    // All four requesting: rotation continues after the last owner (0)
    REQ = 4'b1111;
    wait_gnt("rr_wait", 40);
    prev = 0; hold_low = 0;
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      if (GNT != '0 && int'(GNT) != prev) order.push_back(int'(GNT));
      prev = int'(GNT);
      if (!HOLD) hold_low++;
      @(negedge CLK);
    end
    check("rr_count", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) check("rr_order", order[i], exp_order[i]);
    check("rr_hold_low", hold_low, 0);
    REQ = 4'b0000;
    repeat (15) @(negedge CLK);

    // Sole requester hitting the tenure limit repeatedly
    REQ = 4'b0001;
    wait_gnt("tenure_wait", 40);
    tmo_cnt = 0; hold_low = 0; gnt_cyc = 0;
    for (int c = 0; c < 30; c++) begin
      if (TIMEOUT) tmo_cnt++;
      if (!HOLD) hold_low++;
      if (GNT != '0) gnt_cyc++;
      @(negedge CLK);
    end
    check("tenure_timeouts", tmo_cnt, 3);
    check("tenure_hold_low", hold_low, 0);
    check("tenure_gnt_cycles", gnt_cyc, 27);
    REQ = 4'b0000;
    repeat (15) @(negedge CLK);

    // Request withdrawn before HLDA: no grant may appear
    REQ = 4'b0010;
    @(negedge CLK);
    REQ = 4'b0000;
    gnt_cyc = 0;
    for (int c = 0; c < 20; c++) begin
      if (GNT != '0) gnt_cyc++;
      @(negedge CLK);
    end
    check("withdraw_no_gnt", gnt_cyc, 0);
    check("withdraw_hold_off", int'(HOLD), 0);

    // Randomized traffic with occasional HLDA loss and quiet periods
    drop_en = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      @(negedge CLK);
      rv = int'(REQ);
      g  = int'(GNT);
      for (int i = 0; i < N; i++) begin
        if (((rv >> i) & 1) == 0) begin
          if ((c % 200) < 170 && $urandom_range(0, 7) == 0) rv |= (1 << i);
        end else if (((g >> i) & 1) != 0) begin
          if ($urandom_range(0, 15) == 0) rv &= ~(1 << i);
        end else if ($urandom_range(0, 63) == 0) begin
          rv &= ~(1 << i);
        end
      end
      REQ = rv[N-1:0];
    end
    drop_en = 1'b0;
    REQ = 4'b0000;
    repeat (20) @(negedge CLK);

    // Asynchronous reset in the middle of a grant
    REQ = 4'b1111;
    wait_gnt("areset_wait", 40);
    #2;
    RESET = 1'b0;
    #1;
    check("areset_hold", int'(HOLD), 0);
    check("areset_gnt", int'(GNT), 0);
    check("areset_busy", int'(BUSY), 0);
    REQ = 4'b0000;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    REQ = 4'b0010;
    wait_gnt("post_reset_wait", 40);
    check("post_reset_gnt", int'(GNT), 2);
    REQ = 4'b0000;
    repeat (20) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
